// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared multicycle RV32I datapath (PC, IR, RF, ALU, memory).
// Define MEM_WAIT_EN to stall FETCH/MEM_READ/MEM_WRITE until mem_ready is high.
module multicycle_controller #(
   parameter int STATE_W   = 4,
   parameter int TRAP_HOLD = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_select,
   output logic       ir_write,
   output logic       mem_write,
   output logic       mem_read,
   output logic       reg_write,
   output logic [1:0] ALU_select_A,
   output logic [1:0] ALU_select_B,
   output logic [1:0] result_select,
   output logic       branch,
   output logic [1:0] ALU_op,
   output logic       retired,
   output logic       illegal
);

   typedef enum logic [STATE_W-1:0] {
      FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE,
      EXEC_R, EXEC_I, UPPER, ALU_WB, BRANCH, JAL, TRAP
   } state_t;

   state_t state, state_next;
   logic   pc_update;
   logic   adv;

`ifdef MEM_WAIT_EN
   assign adv = mem_ready;
`else
   logic unused_mem_ready;
   assign adv = 1'b1;
   assign unused_mem_ready = mem_ready;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   always_comb begin
      state_next    = FETCH;
      pc_update     = 1'b0;
      adr_select    = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      mem_read      = 1'b0;
      reg_write     = 1'b0;
      ALU_select_A  = 2'b00;
      ALU_select_B  = 2'b00;
      result_select = 2'b00;
      branch        = 1'b0;
      ALU_op        = 2'b00;
      retired       = 1'b0;
      illegal       = 1'b0;
      case (state)
         FETCH: begin
            mem_read      = 1'b1;
            ir_write      = adv;
            pc_update     = adv;
            ALU_select_B  = 2'b10;
            result_select = 2'b10;
            state_next    = adv ? DECODE : FETCH;
         end
         DECODE: begin
            ALU_select_A = 2'b01;
            ALU_select_B = 2'b01;
            case (opcode)
               7'b0000011, 7'b0100011: state_next = MEM_ADR;
               7'b0110011:             state_next = EXEC_R;
               7'b0010011:             state_next = EXEC_I;
               7'b1100011:             state_next = BRANCH;
               7'b1101111:             state_next = JAL;
               7'b0110111, 7'b0010111: state_next = UPPER;
               default:                state_next = TRAP;
            endcase
         end
         MEM_ADR: begin
            ALU_select_A = 2'b10;
            ALU_select_B = 2'b01;
            state_next   = opcode[5] ? MEM_WRITE : MEM_READ;
         end
         MEM_READ: begin
            mem_read   = 1'b1;
            adr_select = 1'b1;
            state_next = adv ? MEM_WB : MEM_READ;
         end
         MEM_WB: begin
            reg_write     = 1'b1;
            result_select = 2'b01;
            retired       = 1'b1;
         end
         MEM_WRITE: begin
            // write strobe stays up through the stall; memory is idempotent
            mem_write  = 1'b1;
            adr_select = 1'b1;
            retired    = adv;
            state_next = adv ? FETCH : MEM_WRITE;
         end
         EXEC_R: begin
            ALU_select_A = 2'b10;
            ALU_op       = 2'b10;
            state_next   = ALU_WB;
         end
         EXEC_I: begin
            ALU_select_A = 2'b10;
            ALU_select_B = 2'b01;
            ALU_op       = 2'b10;
            state_next   = ALU_WB;
         end
         UPPER: begin
            ALU_select_A = opcode[5] ? 2'b11 : 2'b01;
            ALU_select_B = 2'b01;
            state_next   = ALU_WB;
         end
         ALU_WB: begin
            reg_write = 1'b1;
            retired   = 1'b1;
         end
         BRANCH: begin
            ALU_select_A = 2'b10;
            ALU_op       = 2'b01;
            branch       = 1'b1;
            retired      = 1'b1;
         end
         JAL: begin
            // link value old_PC+4 lands in ALU_out while PC takes the target
            ALU_select_A = 2'b01;
            ALU_select_B = 2'b10;
            pc_update    = 1'b1;
            state_next   = ALU_WB;
         end
         TRAP: begin
            illegal    = 1'b1;
            state_next = (TRAP_HOLD != 0) ? TRAP : FETCH;
         end
         default: state_next = FETCH;
      endcase
   end

   assign pc_write = pc_update | (branch & zero);

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM that sequences the shared multicycle RV32I datapath: PC, IR, register file, a single ALU and one unified instruction/data memory port.
- Decodes the IR opcode one state at a time and drives the datapath's select and enable lines.
- Sits beside the ALU decoder, which consumes ALU_op; replaces the single-cycle main decoder in the multicycle CPU build.

Parameters:
- STATE_W, 4, width of the state register (13 states used).
- TRAP_HOLD, 1, 1 = stay in TRAP until reset; 0 = return to FETCH after one cycle.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears the FSM to FETCH.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- zero  in  1  ALU zero flag, already resolved for the branch condition.
- mem_ready  in  1  memory handshake; only used with MEM_WAIT_EN.
- pc_write  out  1  PC load enable (pc_update OR (branch AND zero)).
- adr_select  out  1  memory address source: 0 = PC, 1 = ALU_out.
- ir_write  out  1  latch IR and old_PC.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read request.
- reg_write  out  1  register-file write enable.
- ALU_select_A  out  2  00 = PC, 01 = old_PC, 10 = rs1, 11 = zero.
- ALU_select_B  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- result_select  out  2  00 = ALU_out, 01 = read data, 10 = ALU result.
- branch  out  1  branch-evaluation cycle.
- ALU_op  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded.
- retired  out  1  one-cycle pulse in the last state of each instruction.
- illegal  out  1  high while in TRAP.

Behaviour:
- Reset (asynchronous, any cycle, including mid-instruction): state = FETCH. Registered state only; all outputs are combinational from state (plus zero for pc_write).
- Outputs not listed for a state are 0 (selects 00).
- FETCH: mem_read=1, adr_select=0, ir_write=1, A=00, B=10, ALU_op=00, result=10, pc_update=1 → DECODE.
- DECODE: A=01, B=01, ALU_op=00 (branch/jal target into ALU_out). Next state by opcode:
  - 0000011 or 0100011 → MEM_ADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 or 0010111 → UPPER
  - anything else → TRAP
- MEM_ADR: A=10, B=01, ALU_op=00. Next is MEM_READ if opcode[5]=0, MEM_WRITE if opcode[5]=1.
- MEM_READ: mem_read=1, adr_select=1, result=00 → MEM_WB.
- MEM_WB: reg_write=1, result=01, retired=1 → FETCH.
- MEM_WRITE: mem_write=1, adr_select=1, retired=1 → FETCH.
- EXEC_R: A=10, B=00, ALU_op=10 → ALU_WB.
- EXEC_I: A=10, B=01, ALU_op=10 → ALU_WB.
- UPPER: A=11 for lui (opcode[5]=1) or 01 for auipc; B=01; ALU_op=00 → ALU_WB.
- ALU_WB: reg_write=1, result=00, retired=1 → FETCH.
- BRANCH: A=10, B=00, ALU_op=01, result=00, branch=1; pc_write = zero; retired=1 → FETCH.
- JAL: A=01, B=10, result=00, pc_update=1, ALU_op=00 → ALU_WB. Link = old_PC+4; ALU_WB writes rd.
- Instruction latencies (cycles): lw 5, sw 4, R/I 4, lui/auipc 4, jal 4, branch 3.
- TRAP: illegal=1; no enables asserted. Next is TRAP if TRAP_HOLD=1, FETCH if TRAP_HOLD=0. retired is never asserted in TRAP.
- Unused state encodings → FETCH on the next clock.

Optional Feature:
- MEM_WAIT_EN defined: FETCH, MEM_READ and MEM_WRITE hold their state and outputs while mem_ready=0 and advance on the first cycle with mem_ready=1.
  - ir_write and pc_update are asserted only in the FETCH cycle where mem_ready=1.
  - mem_write is asserted every cycle of the hold; memory is idempotent.
  - retired pulses only on the advancing cycle.
- MEM_WAIT_EN undefined: mem_ready is ignored and every memory state is one cycle.

Test Plan:
- Assert reset mid-MEM_READ for 3 cycles, release → first cycle after release is FETCH with mem_read=1 and ir_write=1; no reg_write seen.
- opcode=0000011 (lw) after reset → state sequence FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB; reg_write=1 with result_select=01 only in cycle 5; retired pulse in cycle 5.
- opcode=1100011 with zero=1, then with zero=0 → pc_write=1 in cycle 3 only in the zero=1 case; ALU_op=01 in cycle 3; 3-cycle latency in both cases.
- opcode=0110111 (lui) → UPPER with ALU_select_A=11, ALU_select_B=01; opcode=0010111 (auipc) → ALU_select_A=01; both retire in cycle 4.
- opcode=1110011 with TRAP_HOLD=1 → illegal stays 1 for 10 cycles with no enables; with TRAP_HOLD=0 → illegal high 1 cycle, then FETCH.
- MEM_WAIT_EN defined, sw with mem_ready low 3 cycles → MEM_WRITE lasts 4 cycles with mem_write=1 throughout; retired pulses once, on the 4th cycle.
